// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for the bit-serial subtractor.
// The master drives the operands and start; the slave returns status and the result.
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] in_data1;
   logic [WIDTH-1:0] in_data2;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out_data;
   logic             bw;
   logic             zr;

   modport master (
      output start, in_data1, in_data2,
      input  busy, done, out_data, bw, zr
   );

   modport slave (
      input  start, in_data1, in_data2,
      output busy, done, out_data, bw, zr
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: out_data = in_data1 - in_data2 (mod 2^WIDTH), one bit per clock,
// LSB first, with a borrow flag and a zero flag held until the next completion.
module serial_subtractor #(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_subtractor_if.slave bus
);

   localparam int unsigned    CntW    = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             bw_q, bw_d;
   logic             zr_q, zr_d;
   logic             done_q, done_d;

   logic             a_bit;
   logic             b_bit;
   logic             diff_bit;
   logic             br_next;
   logic [WIDTH-1:0] res_shift;

   // One full-subtractor cell reused every cycle.
   assign a_bit     = a_q[0];
   assign b_bit     = b_q[0];
   assign diff_bit  = a_bit ^ b_bit ^ br_q;
   assign br_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
   assign res_shift = {diff_bit, res_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      bw_d    = bw_q;
      zr_d    = zr_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               a_d     = bus.in_data1;
               b_d     = bus.in_data2;
               br_d    = 1'b0;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = res_shift;
            br_d  = br_next;
            cnt_d = cnt_q + 1'b1;
            // Outputs only move on the completing edge; they hold the last result while running.
            if (cnt_q == LastBit) begin
               out_d   = res_shift;
               bw_d    = br_next;
               zr_d    = (res_shift == '0);
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         out_q   <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bw_q    <= 1'b0;
         zr_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         bw_q    <= bw_d;
         zr_q    <= zr_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy     = (state_q == StRun);
   assign bus.done     = done_q;
   assign bus.out_data = out_q;
   assign bus.bw       = bw_q;
   assign bus.zr       = zr_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: 4-bit and 8-bit instances share clock and reset.
module tb_serial_subtractor;

   typedef struct packed {
      logic [7:0] diff;
      logic       bw;
      logic       zr;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   exp_t sb4[$];
   exp_t sb8[$];

   serial_subtractor_if #(.WIDTH(4)) b4 ();
   serial_subtractor_if #(.WIDTH(8)) b8 ();

   serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
   serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Drive one start pulse and push the model result; returns 1 time unit after the accepting edge.
   task automatic launch(input bit w8, input logic [7:0] x, input logic [7:0] y);
      exp_t       e;
      logic [3:0] d4;
      logic [7:0] d8;
      if (w8) begin
         d8     = x - y;
         e.diff = d8;
         e.bw   = (x < y);
         e.zr   = (d8 == 8'd0);
         b8.start    = 1'b1;
         b8.in_data1 = x;
         b8.in_data2 = y;
         sb8.push_back(e);
      end else begin
         d4     = x[3:0] - y[3:0];
         e.diff = {4'd0, d4};
         e.bw   = (x[3:0] < y[3:0]);
         e.zr   = (d4 == 4'd0);
         b4.start    = 1'b1;
         b4.in_data1 = x[3:0];
         b4.in_data2 = y[3:0];
         sb4.push_back(e);
      end
      @(posedge clk);
      #1;
      b4.start = 1'b0;
      b8.start = 1'b0;
   endtask

   // Bounded wait for done, sampling on falling edges; lat = -1 on timeout.
   task automatic wait_done(input bit w8, output int lat, output int busy_cyc);
      lat      = -1;
      busy_cyc = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (w8 ? b8.busy : b4.busy) busy_cyc++;
         if (w8 ? b8.done : b4.done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if ({b4.busy, b4.done, b4.out_data, b4.bw, b4.zr} !== 8'd0) begin
         failures++;
         $display("FAIL reset_w4: got busy=%b done=%b out=%0d bw=%b zr=%b, expected all 0",
                  b4.busy, b4.done, b4.out_data, b4.bw, b4.zr);
      end
      checks++;
      if ({b8.busy, b8.done, b8.out_data, b8.bw, b8.zr} !== 12'd0) begin
         failures++;
         $display("FAIL reset_w8: got busy=%b done=%b out=%0d bw=%b zr=%b, expected all 0",
                  b8.busy, b8.done, b8.out_data, b8.bw, b8.zr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({b4.busy, b4.done, b4.out_data, b4.bw, b4.zr} !== 8'd0) begin
         failures++;
         $display("FAIL idle_after_reset: got busy=%b done=%b out=%0d, expected all 0",
                  b4.busy, b4.done, b4.out_data);
      end
   endtask

   task automatic test_basic();
      int   lat, bc;
      exp_t e;
      launch(1'b0, 8'd9, 8'd3);
      wait_done(1'b0, lat, bc);
      checks++;
      if (lat !== 5) begin
         failures++;
         $display("FAIL basic_latency: got %0d falling edges after accept, expected 5", lat);
      end
      checks++;
      if (bc !== 4) begin
         failures++;
         $display("FAIL basic_busy_cycles: got %0d, expected 4", bc);
      end
      e = sb4.pop_front();
      checks++;
      if ({b4.out_data, b4.bw, b4.zr} !== {e.diff[3:0], e.bw, e.zr}) begin
         failures++;
         $display("FAIL basic_result: got out=%0d bw=%b zr=%b, expected out=%0d bw=%b zr=%b",
                  b4.out_data, b4.bw, b4.zr, e.diff[3:0], e.bw, e.zr);
      end
      @(negedge clk);
      checks++;
      if ({b4.done, b4.busy, b4.out_data} !== {2'b00, 4'd6}) begin
         failures++;
         $display("FAIL done_one_cycle: got done=%b busy=%b out=%0d, expected done=0 busy=0 out=6",
                  b4.done, b4.busy, b4.out_data);
      end
   endtask

   task automatic test_vectors();
      logic [7:0] xs[3];
      logic [7:0] ys[3];
      int         lat, bc;
      exp_t       e;
      xs = '{8'd3, 8'd5, 8'd0};
      ys = '{8'd9, 8'd5, 8'd15};
      for (int i = 0; i < 3; i++) begin
         launch(1'b0, xs[i], ys[i]);
         wait_done(1'b0, lat, bc);
         e = sb4.pop_front();
         checks++;
         if (lat !== 5 || {b4.out_data, b4.bw, b4.zr} !== {e.diff[3:0], e.bw, e.zr}) begin
            failures++;
            $display("FAIL vector_%0d-%0d: got lat=%0d out=%0d bw=%b zr=%b, expected lat=5 out=%0d bw=%b zr=%b",
                     xs[i], ys[i], lat, b4.out_data, b4.bw, b4.zr, e.diff[3:0], e.bw, e.zr);
         end
      end
   endtask

   task automatic test_ignore_start();
      int   pulses;
      exp_t e;
      pulses = 0;
      launch(1'b0, 8'd10, 8'd6);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 1) begin
            b4.start    = 1'b1;
            b4.in_data1 = 4'd1;
            b4.in_data2 = 4'd2;
         end
         if (i == 2) b4.start = 1'b0;
         if (b4.done) begin
            pulses++;
            e = sb4.pop_front();
            checks++;
            if ({b4.out_data, b4.bw, b4.zr} !== {e.diff[3:0], e.bw, e.zr}) begin
               failures++;
               $display("FAIL ignore_start_result: got out=%0d bw=%b zr=%b, expected out=%0d bw=%b zr=%b",
                        b4.out_data, b4.bw, b4.zr, e.diff[3:0], e.bw, e.zr);
            end
         end
      end
      checks++;
      if (pulses !== 1) begin
         failures++;
         $display("FAIL ignore_start_pulses: got %0d done pulses, expected 1", pulses);
      end
   endtask

   task automatic test_back_to_back();
      int   lat, bc, gap;
      bit   held_ok, no_gap;
      exp_t e;
      launch(1'b0, 8'd11, 8'd1);
      wait_done(1'b0, lat, bc);
      e = sb4.pop_front();
      checks++;
      if ({b4.out_data, b4.bw, b4.zr} !== {e.diff[3:0], e.bw, e.zr}) begin
         failures++;
         $display("FAIL b2b_first: got out=%0d, expected %0d", b4.out_data, e.diff[3:0]);
      end
      // Still inside the done cycle: this start must be taken at the next edge.
      launch(1'b0, 8'd7, 8'd2);
      gap     = -1;
      held_ok = 1'b1;
      no_gap  = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (n == 1) no_gap = b4.busy;
         if (b4.done) begin
            gap = n;
            break;
         end
         if (b4.out_data !== 4'd10) held_ok = 1'b0;
      end
      e = sb4.pop_front();
      checks++;
      if (!no_gap) begin
         failures++;
         $display("FAIL b2b_no_idle_gap: got busy=0 right after done cycle, expected busy=1");
      end
      checks++;
      if (gap !== 5) begin
         failures++;
         $display("FAIL b2b_done_spacing: got %0d cycles between done pulses, expected 5", gap);
      end
      checks++;
      if (!held_ok) begin
         failures++;
         $display("FAIL b2b_hold: got out_data changing before second done, expected 10 held");
      end
      checks++;
      if ({b4.out_data, b4.bw, b4.zr} !== {e.diff[3:0], e.bw, e.zr}) begin
         failures++;
         $display("FAIL b2b_second: got out=%0d bw=%b zr=%b, expected out=%0d bw=%b zr=%b",
                  b4.out_data, b4.bw, b4.zr, e.diff[3:0], e.bw, e.zr);
      end
   endtask

   task automatic test_reset_mid_run();
      int   pulses, lat, bc;
      exp_t e;
      pulses = 0;
      launch(1'b0, 8'd9, 8'd3);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({b4.busy, b4.done, b4.out_data, b4.bw, b4.zr} !== 8'd0) begin
         failures++;
         $display("FAIL async_reset_mid_run: got busy=%b done=%b out=%0d bw=%b zr=%b, expected all 0",
                  b4.busy, b4.done, b4.out_data, b4.bw, b4.zr);
      end
      void'(sb4.pop_front());
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (b4.done) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         failures++;
         $display("FAIL reset_no_done: got %0d done pulses, expected 0", pulses);
      end
      launch(1'b0, 8'd12, 8'd4);
      wait_done(1'b0, lat, bc);
      e = sb4.pop_front();
      checks++;
      if (lat !== 5 || {b4.out_data, b4.bw, b4.zr} !== {e.diff[3:0], e.bw, e.zr}) begin
         failures++;
         $display("FAIL after_reset_op: got lat=%0d out=%0d bw=%b, expected lat=5 out=%0d bw=%b",
                  lat, b4.out_data, b4.bw, e.diff[3:0], e.bw);
      end
   endtask

   task automatic test_width8();
      logic [7:0] xs[2];
      logic [7:0] ys[2];
      int         lat, bc;
      exp_t       e;
      xs = '{8'd200, 8'd1};
      ys = '{8'd1, 8'd2};
      for (int i = 0; i < 2; i++) begin
         launch(1'b1, xs[i], ys[i]);
         wait_done(1'b1, lat, bc);
         e = sb8.pop_front();
         checks++;
         if (lat !== 9 || bc !== 8) begin
            failures++;
            $display("FAIL w8_timing_%0d: got lat=%0d busy=%0d, expected lat=9 busy=8", i, lat, bc);
         end
         checks++;
         if ({b8.out_data, b8.bw, b8.zr} !== {e.diff, e.bw, e.zr}) begin
            failures++;
            $display("FAIL w8_result_%0d-%0d: got out=%0d bw=%b zr=%b, expected out=%0d bw=%b zr=%b",
                     xs[i], ys[i], b8.out_data, b8.bw, b8.zr, e.diff, e.bw, e.zr);
         end
      end
   endtask

   task automatic test_sweep();
      int   lat, bc;
      exp_t e;
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            launch(1'b0, 8'(x), 8'(y));
            wait_done(1'b0, lat, bc);
            e = sb4.pop_front();
            checks++;
            if (lat !== 5 || {b4.out_data, b4.bw, b4.zr} !== {e.diff[3:0], e.bw, e.zr}) begin
               failures++;
               $display("FAIL sweep_%0d-%0d: got lat=%0d out=%0d bw=%b zr=%b, expected lat=5 out=%0d bw=%b zr=%b",
                        x, y, lat, b4.out_data, b4.bw, b4.zr, e.diff[3:0], e.bw, e.zr);
            end
         end
      end
   endtask

   initial begin
      clk         = 1'b0;
      rst_n       = 1'b0;
      checks      = 0;
      failures    = 0;
      b4.start    = 1'b0;
      b4.in_data1 = '0;
      b4.in_data2 = '0;
      b8.start    = 1'b0;
      b8.in_data1 = '0;
      b8.in_data2 = '0;

      test_reset();
      test_basic();
      test_vectors();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_run();
      test_width8();
      test_sweep();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
